// File: rtl/param_serializer.sv
// rtl/param_serializer.sv - parameterised parallel-to-serial shifter with optional parity bit
module param_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter bit LSB_FIRST  = 1'b1,
    parameter bit PARITY_EN  = 1'b1
) (
    input  logic                  clk,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Load,
    input  logic                  ser_en,
    input  logic                  par_type,
    input  logic                  clr,
    output logic                  ser_data,
    output logic                  ser_done,
    output logic                  busy
);
    localparam int CNT_W = (DATA_WIDTH <= 2) ? 1 : $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_q, par_d;
    logic                  ser_data_q, ser_data_d;
    logic                  ser_done_q, ser_done_d;
    logic [CNT_W-1:0]      bit_sel;

    assign bit_sel = LSB_FIRST ? cnt_q : (CNT_LAST - cnt_q);

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            data_q     <= '0;
            par_q      <= 1'b0;
            ser_data_q <= 1'b0;
            ser_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            par_q      <= par_d;
            ser_data_q <= ser_data_d;
            ser_done_q <= ser_done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        par_d      = par_q;
        ser_data_d = ser_data_q;
        ser_done_d = 1'b0;
        if (clr) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Load wins over a simultaneous strobe: nothing is emitted on the capture edge
                    if (Load) begin
                        data_d  = P_DATA;
                        par_d   = (^P_DATA) ^ par_type;
                        cnt_d   = '0;
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    if (ser_en) begin
                        ser_data_d = data_q[bit_sel];
                        if (cnt_q == CNT_LAST) begin
                            // Wrap to 0 rather than overflow past the last index
                            cnt_d = '0;
                            if (PARITY_EN) begin
                                state_d = PARITY;
                            end else begin
                                state_d    = IDLE;
                                ser_done_d = 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (ser_en) begin
                        ser_data_d = par_q;
                        ser_done_d = 1'b1;
                        state_d    = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign ser_data = ser_data_q;
    assign ser_done = ser_done_q;
    assign busy     = (state_q != IDLE);
endmodule

// File: doc/param_serializer.md
PARAM_SERIALIZER -- requirements
Module: param_serializer

Interface
REQ-001 Parameter DATA_WIDTH, default 8: number of data bits per frame; legal range 2..32.
REQ-002 Parameter LSB_FIRST, default 1: 1 sends bit 0 first; 0 sends bit DATA_WIDTH-1 first.
REQ-003 Parameter PARITY_EN, default 1: 1 appends one parity bit after the data bits; 0 sends no parity bit.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 RST  input  1  asynchronous, active-high reset.
REQ-006 P_DATA  input  DATA_WIDTH  parallel word to serialise.
REQ-007 Load  input  1  capture request for P_DATA.
REQ-008 ser_en  input  1  shift strobe; one bit is emitted per sampled-high cycle.
REQ-009 par_type  input  1  parity select: 0 even, 1 odd; sampled with Load.
REQ-010 clr  input  1  synchronous abort.
REQ-011 ser_data  output  1  registered serial bit.
REQ-012 ser_done  output  1  one-cycle pulse marking the final bit of a frame.
REQ-013 busy  output  1  high while a frame is captured and not yet fully emitted.

Function
REQ-014 The block SHALL implement the states IDLE, SHIFT and PARITY; busy SHALL be 1 exactly when the state is not IDLE.
REQ-015 In IDLE with Load=1 at an edge, the block SHALL:
- capture P_DATA into the data register;
- capture the parity bit as (XOR of P_DATA) XOR par_type;
- clear the bit counter to 0;
- enter SHIFT.
busy SHALL go high the following cycle.
REQ-016 Load SHALL be ignored in SHIFT and PARITY; the captured word SHALL NOT change mid-frame.
REQ-017 If Load and ser_en are both high in IDLE, Load SHALL take effect and no bit SHALL be emitted that cycle.
REQ-018 In SHIFT with ser_en=1 at an edge, ser_data SHALL take the bit selected by the counter, and the counter SHALL increment.
- Selected bit is index cnt when LSB_FIRST=1.
- Selected bit is index DATA_WIDTH-1-cnt when LSB_FIRST=0.
REQ-019 Latency: ser_data SHALL update on the same edge that samples ser_en=1 (one-cycle register delay from the strobe).
REQ-020 In SHIFT or PARITY with ser_en=0, the state, counter and ser_data SHALL hold (stall); there is no timeout.
REQ-021 In SHIFT with ser_en=1 and cnt=DATA_WIDTH-1:
- if PARITY_EN=1, the block SHALL enter PARITY;
- if PARITY_EN=0, the block SHALL enter IDLE and assert ser_done on that edge.
REQ-022 In PARITY with ser_en=1, ser_data SHALL take the captured parity bit, ser_done SHALL assert on that edge, and the block SHALL enter IDLE.
REQ-023 ser_done SHALL be high for exactly one cycle per completed frame and low at all other times.
REQ-024 The counter SHALL be max(1, ceil(log2(DATA_WIDTH))) bits wide, SHALL clear on Load, and SHALL never exceed DATA_WIDTH-1.
REQ-025 ser_data SHALL hold its last value while in IDLE.
REQ-026 clr=1 at an edge SHALL:
- force IDLE and clear the counter;
- leave ser_done low;
- leave ser_data holding.
REQ-027 clr SHALL have priority over Load and ser_en in the same cycle.
REQ-028 A new Load SHALL be accepted on the cycle after ser_done (back-to-back frames), with no dead cycle beyond that.

Reset
REQ-029 RST=1 SHALL immediately, without a clock edge, force:
- state IDLE, counter 0, data register 0, parity register 0;
- ser_data 0, ser_done 0, busy 0.
REQ-030 RST asserted mid-frame SHALL abandon the frame; no ser_done SHALL follow its release.
REQ-031 After RST deasserts, the first edge SHALL behave as in IDLE.

Verification
REQ-032 Frame with defaults: DATA_WIDTH=8, LSB_FIRST=1, PARITY_EN=1, P_DATA=8'hA5, par_type=0, Load then ser_en held high.
- Required: ser_data sequence 1,0,1,0,0,1,0,1, then parity 0.
- Required: ser_done pulses with the parity bit; busy high for 9 cycles.
REQ-033 MSB-first with odd parity: DATA_WIDTH=12, LSB_FIRST=0, P_DATA=12'h801, par_type=1.
- Required: bits 1,0,0,0,0,0,0,0,0,0,0,1, then parity 1.
REQ-034 Stall: PARITY_EN=0, P_DATA=8'hFF, with ser_en low for 3 cycles after the 4th bit.
- Required: ser_data holds 1 and the counter holds 4.
- Required: ser_done pulses with the 8th sampled strobe.
REQ-035 Load during busy with P_DATA=8'h00 mid-frame of 8'hA5.
- Required: the emitted frame is still 8'hA5, and 8'h00 is not captured.
REQ-036 Abort and reset: clr after 3 bits, and separately RST mid-frame.
- Required: IDLE next edge (clr) or immediately (RST); busy 0; no ser_done pulse.
- Required: a following Load of 8'h3C serialises correctly from bit 0.
